// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter family: mode encodings for
// the SATURATE parameter and a constant-foldable ceil(log2) used to size the
// optional prescaler (enabled with the COUNTER_PRESCALE_EN macro).
package counter_pkg;

   // Values for the SATURATE parameter.
   localparam int COUNT_WRAP = 0;
   localparam int COUNT_SAT  = 1;

   // Number of bits needed to hold values 0..n-1; never returns less than 1.
   function automatic int clog2(input int n);
      int bits;
      int span;
      bits = 0;
      span = 1;
      while (span < n) begin
         span = span * 2;
         bits = bits + 1;
      end
      if (bits < 1) begin
         bits = 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE: strobe is high on every PRESCALE-th
// enabled cycle. en=0 freezes the phase; restart forces it back to zero.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic en,
   input  logic restart,
   output logic strobe
);

   localparam int PW = clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;

   // Strobe marks the final phase of the division period.
   assign strobe = (phase == LAST);

   // Phase counter: restart wins, otherwise advance on enabled cycles and
   // fold back to zero after the strobe cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
      end else if (restart) begin
         phase <= '0;
      end else if (en) begin
         if (phase == LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down counter with enable, synchronous clear/load, wrap or
// saturate at the bounds, a combinational terminal-count flag, a one-cycle
// wrapped pulse and a sticky saturation flag.
// Optional feature: define COUNTER_PRESCALE_EN to step only once every
// PRESCALE enabled cycles; without it every enabled cycle is a step.
// Legal ranges: WIDTH 2..32, 1 <= MAX <= 2**WIDTH-1, PRESCALE >= 2.
module param_counter
   import counter_pkg::*;
#(
   parameter int              WIDTH    = 5,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter int              SATURATE = COUNT_WRAP,
   parameter int              PRESCALE = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
   localparam logic [WIDTH:0]   MAX_X    = {1'b0, MAX_V};
   localparam bit               SAT_MODE = (SATURATE == COUNT_SAT);

   logic             strobe;
   logic             step;
   logic [WIDTH:0]   inc;
   logic             at_top;
   logic             at_bot;
   logic             bound_hit;
   logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
   // A clear or load also restarts the division period.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (en),
      .restart (clear | load),
      .strobe  (strobe)
   );
`else
   // Without the prescaler every enabled cycle steps; PRESCALE has no effect
   // but stays in the parameter list so both builds share one interface.
   assign strobe = (PRESCALE >= 2) | 1'b1;
`endif

   assign step = en & strobe;

   // Increment is formed one bit wider so the top bound test stays exact
   // even when MAX is the all-ones value of WIDTH bits.
   assign inc          = {1'b0, count} + (WIDTH+1)'(1);
   assign at_top       = (inc > MAX_X);
   assign at_bot       = (count == '0);
   assign bound_hit    = up ? at_top : at_bot;
   assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

   // Terminal count follows the current direction and value.
   assign tc = up ? (count == MAX_V) : (count == '0);

   // Counter state and flags: clear beats load beats step, at most one action.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count   <= '0;
         wrapped <= 1'b0;
         sat     <= 1'b0;
      end else if (clear) begin
         count   <= '0;
         wrapped <= 1'b0;
         sat     <= 1'b0;
      end else if (load) begin
         count   <= load_clamped;
         wrapped <= 1'b0;
      end else if (step) begin
         if (bound_hit) begin
            wrapped <= 1'b1;
            if (SAT_MODE) begin
               // Hold at the bound; the sticky flag records the hit.
               sat <= 1'b1;
            end else begin
               count <= up ? '0 : MAX_V;
            end
         end else begin
            wrapped <= 1'b0;
            count   <= up ? inc[WIDTH-1:0] : (count - WIDTH'(1));
         end
      end else begin
         wrapped <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter. Three instances share clock and reset:
//   a: WIDTH=5 MAX=31 wrap, b: WIDTH=5 MAX=9 wrap, c: WIDTH=5 MAX=9 saturate.
// Each instance has its own inputs; only one instance is driven per cycle,
// the others idle with en/clear/load low.
module tb_param_counter;

   localparam int W = 10;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   // ---------------- DUT signals ----------------
   logic       en_v  [3];
   logic       up_v  [3];
   logic       clr_v [3];
   logic       ld_v  [3];
   logic [4:0] lv_v  [3];

   logic [4:0] cnt_a, cnt_b, cnt_c;
   logic       tc_a, tc_b, tc_c;
   logic       wr_a, wr_b, wr_c;
   logic       sat_a, sat_b, sat_c;

   param_counter #(.WIDTH(5), .MAX(31), .SATURATE(0), .PRESCALE(4)) dut_a (
      .clock(clock), .reset_n(reset_n), .en(en_v[0]), .up(up_v[0]),
      .clear(clr_v[0]), .load(ld_v[0]), .load_value(lv_v[0]),
      .count(cnt_a), .tc(tc_a), .wrapped(wr_a), .sat(sat_a)
   );

   param_counter #(.WIDTH(5), .MAX(9), .SATURATE(0), .PRESCALE(4)) dut_b (
      .clock(clock), .reset_n(reset_n), .en(en_v[1]), .up(up_v[1]),
      .clear(clr_v[1]), .load(ld_v[1]), .load_value(lv_v[1]),
      .count(cnt_b), .tc(tc_b), .wrapped(wr_b), .sat(sat_b)
   );

   param_counter #(.WIDTH(5), .MAX(9), .SATURATE(1), .PRESCALE(4)) dut_c (
      .clock(clock), .reset_n(reset_n), .en(en_v[2]), .up(up_v[2]),
      .clear(clr_v[2]), .load(ld_v[2]), .load_value(lv_v[2]),
      .count(cnt_c), .tc(tc_c), .wrapped(wr_c), .sat(sat_c)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_bad = 0;

   // Reference state per instance, updated from every pushed expectation.
   int m_cnt [3];
   bit m_wr  [3];
   bit m_sat [3];

   typedef struct {
      int d;
      bit e;
      bit u;
      bit c;
      bit l;
      int lv;
      int ec;
      bit ew;
      bit es;
   } vec_t;
   vec_t tbl[$];

   function automatic int max_of(input int d);
      return (d == 0) ? 31 : 9;
   endfunction

   function automatic bit sat_mode_of(input int d);
      return (d == 2);
   endfunction

   // Record layout: {instance[1:0], count[4:0], wrapped, sat, tc}.
   function automatic logic [W-1:0] pack(input int d, input int c, input bit w,
                                         input bit s, input bit t);
      logic [31:0] dd;
      logic [31:0] cc;
      dd = d;
      cc = c;
      return {dd[1:0], cc[4:0], w, s, t};
   endfunction

   function automatic logic [W-1:0] actual(input int d);
      case (d)
         0:       return pack(0, int'(cnt_a), wr_a, sat_a, tc_a);
         1:       return pack(1, int'(cnt_b), wr_b, sat_b, tc_b);
         default: return pack(2, int'(cnt_c), wr_c, sat_c, tc_c);
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   task automatic push_exp(input int d, input int ec, input bit ew, input bit es);
      bit et;
      et = up_v[d] ? (ec == max_of(d)) : (ec == 0);
      exp_q.push_back(pack(d, ec, ew, es, et));
      for (int k = 0; k < 3; k++) begin
         if (k == d) begin
            m_cnt[k] = ec;
            m_wr[k]  = ew;
            m_sat[k] = es;
         end
      end
   endtask

   task automatic check_out(input int d, input string nm);
      logic [W-1:0] e;
      logic [W-1:0] a;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty for instance %0d", nm, d);
      end else begin
         e = exp_q.pop_front();
         a = actual(d);
         if (a !== e) begin
            n_bad++;
            $display("FAIL %s inst=%0d: got count=%0d wrapped=%b sat=%b tc=%b, want count=%0d wrapped=%b sat=%b tc=%b",
                     nm, d, a[7:3], a[2], a[1], a[0], e[7:3], e[2], e[1], e[0]);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      for (int k = 0; k < 3; k++) begin
         en_v[k]  = 1'b0;
         clr_v[k] = 1'b0;
         ld_v[k]  = 1'b0;
      end
   endtask

   // Drive one instance for one edge, push its expectation, check after edge.
   task automatic apply(input int d, input bit e, input bit u, input bit c,
                        input bit l, input int lv, input int ec, input bit ew,
                        input bit es, input string nm);
      logic [31:0] lvb;
      lvb      = lv;
      en_v[d]  = e;
      up_v[d]  = u;
      clr_v[d] = c;
      ld_v[d]  = l;
      lv_v[d]  = lvb[4:0];
      push_exp(d, ec, ew, es);
      // Idle instances see en=0, so their wrapped pulse drops.
      for (int k = 0; k < 3; k++) begin
         if (k != d) m_wr[k] = 1'b0;
      end
      @(posedge clock);
      #1;
      check_out(d, nm);
      set_idle();
   endtask

   // Reference next state for randomly chosen inputs.
   task automatic rand_step(input int d);
      bit e, u, c, l;
      int lv, mx, cur, ec;
      bit ew, es;
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1);
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      lv = $urandom_range(0, 31);
      mx = max_of(d);
      cur = m_cnt[d];
      ec = cur;
      ew = 1'b0;
      es = m_sat[d];
      if (c) begin
         ec = 0;
         es = 1'b0;
      end else if (l) begin
         ec = (lv > mx) ? mx : lv;
      end else if (e) begin
         if (u && cur == mx) begin
            ew = 1'b1;
            if (sat_mode_of(d)) es = 1'b1;
            else ec = 0;
         end else if (!u && cur == 0) begin
            ew = 1'b1;
            if (sat_mode_of(d)) es = 1'b1;
            else ec = mx;
         end else begin
            ec = u ? cur + 1 : cur - 1;
         end
      end
      apply(d, e, u, c, l, lv, ec, ew, es, "random");
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         up_v[k]  = 1'b1;
         lv_v[k]  = '0;
         m_cnt[k] = 0;
         m_wr[k]  = 1'b0;
         m_sat[k] = 1'b0;
      end
      set_idle();
      repeat (2) @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
         push_exp(k, 0, 1'b0, 1'b0);
         check_out(k, "reset_state");
      end
      @(negedge clock);
      reset_n = 1'b1;

`ifndef COUNTER_PRESCALE_EN
      // Instance a: free run up through the wrap, stopping at count 17.
      for (int i = 0; i < 49; i++) begin
         int ec;
         ec = (i + 1) % 32;
         apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, ec, (ec == 0), 1'b0, "a_wrap_run");
      end

      // Instance c: count up into saturation and hold.
      for (int i = 0; i < 12; i++) begin
         int ec;
         ec = (i + 1 > 9) ? 9 : i + 1;
         apply(2, 1'b1, 1'b1, 1'b0, 1'b0, 0, ec, (i + 1 > 9), (i + 1 > 9), "c_sat_run");
      end

      // Table: {inst, en, up, clear, load, load_value, count, wrapped, sat}.
      tbl.push_back('{1, 1'b0, 1'b0, 1'b0, 1'b1,  3, 3, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 2, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 1, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 9, 1'b1, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 8, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b1, 1'b1, 1'b1,  5, 0, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1, 20, 9, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b1, 1'b0});
      tbl.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b0, 1'b1, 1'b0, 1'b1,  9, 9, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b1, 31, 9, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 8, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0,  0, 9, 1'b0, 1'b0});
      tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1'b0, 1'b1});
      tbl.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1, 1'b1});
      tbl.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1, 1'b1});
      tbl.push_back('{2, 1'b1, 1'b1, 1'b1, 1'b0,  0, 0, 1'b0, 1'b0});
      tbl.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b1,  9, 9, 1'b0, 1'b0});
      tbl.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0,  0, 9, 1'b1, 1'b1});
      tbl.push_back('{2, 1'b0, 1'b1, 1'b0, 1'b0,  0, 9, 1'b0, 1'b1});
      tbl.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0,  0, 8, 1'b0, 1'b1});
      tbl.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0,  0, 9, 1'b0, 1'b1});
      tbl.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0,  0, 9, 1'b1, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].d, tbl[i].e, tbl[i].u, tbl[i].c, tbl[i].l, tbl[i].lv,
               tbl[i].ec, tbl[i].ew, tbl[i].es, $sformatf("tbl%0d", i));
      end

      // Mid-operation reset between edges: a holds 17, c holds sat=1.
      #2;
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         push_exp(k, 0, 1'b0, 1'b0);
         check_out(k, "async_reset");
      end
      @(negedge clock);
      reset_n = 1'b1;

      // Random traffic against the reference state.
      for (int i = 0; i < 300; i++) begin
         rand_step($urandom_range(0, 2));
      end
`else
      // Prescaled run on instance a: one step per four enabled cycles,
      // with a two-cycle en=0 gap that delays the third step by two cycles.
      for (int i = 1; i <= 18; i++) begin
         bit e;
         int ec;
         e  = !(i == 11 || i == 12);
         if (i <= 10)      ec = i / 4;
         else if (i <= 13) ec = 2;
         else if (i <= 17) ec = 3;
         else              ec = 4;
         apply(0, e, 1'b1, 1'b0, 1'b0, 0, ec, 1'b0, 1'b0, "prescale_run");
      end
      // Load restarts the division period.
      apply(0, 1'b1, 1'b1, 1'b0, 1'b1, 7, 7, 1'b0, 1'b0, "prescale_load");
      for (int i = 1; i <= 4; i++) begin
         apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, (i == 4) ? 8 : 7, 1'b0, 1'b0, "prescale_after_load");
      end
`endif

      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL leftover: %0d expectations never checked", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
